// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: synchronises and debounces the 3x3 keypad plus new-game key,
// holds the board, enforces alternating legal moves and reports win/draw to the display stage.
//
// state   | meaning
// S_PLAY  | waiting for a debounced cell press from the player in turn_q
// S_CHECK | one cycle scoring the freshly written board for the mover
// S_OVER  | game decided; cell presses only flag illegal until new game
module ttt_game_ctrl #(
   parameter int DB_CYCLES = 50000
) (
   input  logic        freq_i,
   input  logic        rst_i,
   input  logic [9:0]  keys_i,
   output logic [17:0] board_o,
   output logic [1:0]  turn_o,
   output logic [1:0]  winner_o,
   output logic        game_over_o,
   output logic [7:0]  win_line_o,
   output logic        illegal_o
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_RELOAD = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] DB_ONE    = CW'(1);

   typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

   logic [9:0]    sync1_q, sync2_q, stab_q;
   logic [CW-1:0] cnt_q;
   logic          armed_q, evt_q;
   logic [3:0]    evt_idx_q;

   state_t        state_q;
   logic [17:0]   board_q;
   logic [1:0]    turn_q, winner_q;
   logic          game_over_q, illegal_q;
   logic [7:0]    win_line_q;
   logic [3:0]    move_cnt_q;

   logic          changed, tc, onehot;
   logic [3:0]    key_idx;
   logic [1:0]    cell_cur;
   logic [7:0]    line_hit;

   function automatic logic trio(input logic [17:0] b, input logic [1:0] p,
                                 input int a, input int c, input int d);
      return (b[2*a +: 2] == p) && (b[2*c +: 2] == p) && (b[2*d +: 2] == p);
   endfunction

   always_comb begin
      changed = (sync2_q != stab_q);
      tc      = !changed && (cnt_q == DB_ONE);
      onehot  = $onehot(stab_q);
      key_idx = 4'd0;
      for (int i = 0; i < 10; i++)
         if (stab_q[i]) key_idx = 4'(i);
      cell_cur = 2'd0;
      for (int i = 0; i < 9; i++)
         if (evt_idx_q == 4'(i)) cell_cur = board_q[2*i +: 2];
      line_hit = {trio(board_q, turn_q, 2, 4, 6), trio(board_q, turn_q, 0, 4, 8),
                  trio(board_q, turn_q, 6, 7, 8), trio(board_q, turn_q, 3, 4, 5),
                  trio(board_q, turn_q, 0, 1, 2), trio(board_q, turn_q, 2, 5, 8),
                  trio(board_q, turn_q, 1, 4, 7), trio(board_q, turn_q, 0, 3, 6)};
   end

   always_ff @(posedge freq_i or negedge rst_i) begin
      if (!rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= keys_i;
         sync2_q <= sync1_q;
      end
   end

   // One event per one-hot hold; only an all-released stable vector re-arms.
   always_ff @(posedge freq_i or negedge rst_i) begin
      if (!rst_i) begin
         stab_q    <= '0;
         cnt_q     <= '0;
         armed_q   <= 1'b1;
         evt_q     <= 1'b0;
         evt_idx_q <= 4'd0;
      end else begin
         evt_q <= 1'b0;
         if (changed) begin
            stab_q <= sync2_q;
            cnt_q  <= DB_RELOAD;
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DB_ONE;
         end
         if (tc) begin
            if (stab_q == '0) begin
               armed_q <= 1'b1;
            end else if (armed_q && onehot) begin
               evt_q     <= 1'b1;
               evt_idx_q <= key_idx;
               armed_q   <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge freq_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_PLAY;
         board_q     <= '0;
         turn_q      <= 2'd1;
         winner_q    <= 2'd0;
         game_over_q <= 1'b0;
         win_line_q  <= '0;
         illegal_q   <= 1'b0;
         move_cnt_q  <= 4'd0;
      end else begin
         illegal_q <= 1'b0;
         if (evt_q && evt_idx_q == 4'd9) begin
            state_q     <= S_PLAY;
            board_q     <= '0;
            turn_q      <= 2'd1;
            winner_q    <= 2'd0;
            game_over_q <= 1'b0;
            win_line_q  <= '0;
            move_cnt_q  <= 4'd0;
         end else begin
            case (state_q)
               S_PLAY: begin
                  if (evt_q) begin
                     if (cell_cur == 2'd0) begin
                        for (int i = 0; i < 9; i++)
                           if (evt_idx_q == 4'(i)) board_q[2*i +: 2] <= turn_q;
                        move_cnt_q <= move_cnt_q + 4'd1;
                        state_q    <= S_CHECK;
                     end else begin
                        illegal_q <= 1'b1;
                     end
                  end
               end
               S_CHECK: begin
                  if (line_hit != '0) begin
                     winner_q    <= turn_q;
                     win_line_q  <= line_hit;
                     game_over_q <= 1'b1;
                     state_q     <= S_OVER;
                  end else if (move_cnt_q == 4'd9) begin
                     winner_q    <= 2'd3;
                     game_over_q <= 1'b1;
                     state_q     <= S_OVER;
                  end else begin
                     turn_q  <= (turn_q == 2'd1) ? 2'd2 : 2'd1;
                     state_q <= S_PLAY;
                  end
               end
               S_OVER: begin
                  if (evt_q) illegal_q <= 1'b1;
               end
               default: state_q <= S_PLAY;
            endcase
         end
      end
   end

   assign board_o     = board_q;
   assign turn_o      = turn_q;
   assign winner_o    = winner_q;
   assign game_over_o = game_over_q;
   assign win_line_o  = win_line_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with DB_CYCLES=4; expected values hand-derived.
module tb_ttt_game_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  keys;
   logic [17:0] board;
   logic [1:0]  turn, winner;
   logic        game_over, illegal;
   logic [7:0]  win_line;

   int n_cmp = 0;
   int n_err = 0;
   int ill_cnt = 0;
   int seen;
   int ill_ref;

   int s_win[5]   = '{0, 1, 4, 2, 8};
   int s_draw[9]  = '{0, 4, 8, 1, 7, 6, 2, 5, 3};
   int s_col[5]   = '{0, 1, 3, 4, 6};
   int s_last[9]  = '{1, 0, 2, 5, 3, 7, 4, 8, 6};

   ttt_game_ctrl #(.DB_CYCLES(4)) dut (
      .freq_i     (clk),
      .rst_i      (rst_n),
      .keys_i     (keys),
      .board_o    (board),
      .turn_o     (turn),
      .winner_o   (winner),
      .game_over_o(game_over),
      .win_line_o (win_line),
      .illegal_o  (illegal)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && illegal) ill_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic move(input int k);
      keys = 10'(1 << k);
      idle(10);
      keys = '0;
      idle(10);
   endtask

   initial begin
      rst_n = 1'b0;
      keys  = '0;
      idle(3);
      chk("rst_board", 32'(board), 0);
      chk("rst_turn", 32'(turn), 1);
      chk("rst_winner", 32'(winner), 0);
      chk("rst_over", 32'(game_over), 0);
      chk("rst_line", 32'(win_line), 0);
      chk("rst_illegal", 32'(illegal), 0);
      rst_n = 1'b1;
      idle(10);
      chk("idle_board", 32'(board), 0);

      // single held key: board at event+1, turn at event+2, one event only
      keys = 10'h010;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (seen == 1) begin
            chk("t1_turn_e2", 32'(turn), 2);
            seen = 2;
         end
         if (seen == 0 && board != '0) begin
            chk("t1_board_e1", 32'(board), 32'h100);
            chk("t1_turn_e1", 32'(turn), 1);
            seen = 1;
         end
      end
      chk("t1_evt_seen", 32'(seen), 2);
      chk("t1_no_repeat", 32'(ill_cnt), 0);
      keys = '0;
      idle(10);

      // bounce and multi-key produce nothing
      keys = 10'h010;
      idle(2);
      keys = '0;
      idle(20);
      chk("t2_bounce_ill", 32'(ill_cnt), 0);
      chk("t2_bounce_board", 32'(board), 32'h100);
      keys = 10'h003;
      idle(20);
      keys = '0;
      idle(10);
      chk("t2_multi_board", 32'(board), 32'h100);
      chk("t2_multi_turn", 32'(turn), 2);
      chk("t2_multi_ill", 32'(ill_cnt), 0);

      // occupied cell
      move(4);
      chk("t3_ill_pulse", 32'(ill_cnt), 1);
      chk("t3_turn", 32'(turn), 2);
      chk("t3_board", 32'(board), 32'h100);

      // new game mid-play
      move(9);
      chk("ng_play_board", 32'(board), 0);
      chk("ng_play_turn", 32'(turn), 1);

      foreach (s_win[i]) move(s_win[i]);
      chk("t4_winner", 32'(winner), 1);
      chk("t4_over", 32'(game_over), 1);
      chk("t4_line", 32'(win_line), 32'h40);
      chk("t4_board", 32'(board), 32'h10129);
      ill_ref = ill_cnt;
      move(5);
      chk("t4_ill_over", 32'(ill_cnt - ill_ref), 1);
      chk("t4_frozen", 32'(board), 32'h10129);
      chk("t4_winner_held", 32'(winner), 1);

      // new game from OVER
      move(9);
      chk("ng_over_board", 32'(board), 0);
      chk("ng_over_turn", 32'(turn), 1);
      chk("ng_over_winner", 32'(winner), 0);
      chk("ng_over_flag", 32'(game_over), 0);
      chk("ng_over_line", 32'(win_line), 0);

      for (int i = 0; i < 8; i++) move(s_draw[i]);
      chk("t5_pre_draw", 32'(winner), 0);
      move(s_draw[8]);
      chk("t5_draw", 32'(winner), 3);
      chk("t5_draw_over", 32'(game_over), 1);
      chk("t5_draw_line", 32'(win_line), 0);
      chk("t5_draw_board", 32'(board), 32'h16A59);

      move(9);
      foreach (s_col[i]) move(s_col[i]);
      chk("t5_col_winner", 32'(winner), 1);
      chk("t5_col_line", 32'(win_line), 32'h01);

      // win completed on the ninth move is a win, not a draw
      move(9);
      foreach (s_last[i]) move(s_last[i]);
      chk("t5_9th_winner", 32'(winner), 1);
      chk("t5_9th_line", 32'(win_line), 32'h80);

      // reset during debounce
      move(9);
      move(4);
      chk("t6_pre_board", 32'(board), 32'h100);
      ill_ref = ill_cnt;
      keys = 10'h008;
      idle(3);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_board", 32'(board), 0);
      chk("t6_rst_turn", 32'(turn), 1);
      chk("t6_rst_ill", 32'(illegal), 0);
      keys = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      chk("t6_no_stale", 32'(board), 0);
      chk("t6_no_stale_ill", 32'(ill_cnt - ill_ref), 0);
      move(3);
      chk("t6_after_move", 32'(board), 32'h40);
      chk("t6_after_turn", 32'(turn), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
